pll_lock_seq: RTL
=================

PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 SHALL provide parameter NUM_PLL, default 2, number of independent PLL channels (1..4).
REQ-002 SHALL provide parameter RST_CYCLES, default 16, pll_rst pulse width in cycles (>=2).
REQ-003 SHALL provide parameter LOCK_STABLE_CYCLES, default 64, consecutive synchronised-lock cycles required before release (>=1).
REQ-004 SHALL provide parameter LOCK_TIMEOUT_CYCLES, default 4096, maximum wait for lock per attempt (>=2).
REQ-005 SHALL provide parameter MAX_RETRY, default 3, timeout retries before failure (0..15).
REQ-006 Port: clkin1  in  1  sole clock; reset is synchronous and active-high.
REQ-007 Port: rst  in  1  synchronous active-high reset, sampled on the rising edge of clkin1.
REQ-008 Port: pll_lock  in  NUM_PLL  per-channel PLL lock, asynchronous to clkin1.
REQ-009 Port: restart_req  in  NUM_PLL  per-channel one-cycle restart request.
REQ-010 Port: pll_rst  out  NUM_PLL  per-channel PLL reset, active-high.
REQ-011 Port: clkout0_gate  out  NUM_PLL  per-channel output-clock gate enable.
REQ-012 Port: ready  out  NUM_PLL  channel locked and released.
REQ-013 Port: fail  out  NUM_PLL  channel has exhausted its retries.
REQ-014 Port: lock_lost  out  NUM_PLL  sticky flag: lock dropped while in RUN.
REQ-015 Port: all_ready  out  1  AND of all ready bits.

Function
REQ-016 Each channel SHALL synchronise pll_lock[i] through 2 flops into lock_s; all decisions SHALL use lock_s only.
REQ-017 Each channel SHALL run an independent FSM with states RESET, WAIT_LOCK, STABLE, RUN and FAIL, a shared-width counter cnt, and a retry counter rty.
REQ-018 RESET: pll_rst=1; cnt increments each cycle; at cnt==RST_CYCLES-1 -> WAIT_LOCK with cnt=0.
REQ-019 WAIT_LOCK: pll_rst=0; lock_s=1 -> STABLE with cnt=0; else at cnt==LOCK_TIMEOUT_CYCLES-1, if rty==MAX_RETRY -> FAIL, otherwise rty+1 and -> RESET with cnt=0.
REQ-020 STABLE: lock_s=0 -> WAIT_LOCK with cnt=0 (no pll_rst pulse, rty unchanged); lock_s=1 at cnt==LOCK_STABLE_CYCLES-1 -> RUN.
REQ-021 RUN: clkout0_gate=1, ready=1; lock_s=0 -> RESET with cnt=0 and rty=0, and lock_lost set.
REQ-022 FAIL: pll_rst=1, fail=1, clkout0_gate=0; remains in FAIL until restart_req or rst.
REQ-023 restart_req[i] SHALL force RESET with cnt=0 and rty=0, and clear lock_lost, from any state; it has priority over every lock or timeout event in the same cycle.
REQ-024 All outputs except all_ready SHALL be registered Moore decodes of the state register; all_ready SHALL be the combinational AND of the ready bits.
REQ-025 Counter width SHALL be $clog2 of the largest of RST_CYCLES, LOCK_STABLE_CYCLES and LOCK_TIMEOUT_CYCLES; the counter SHALL never wrap within a state.
REQ-026 Total lock attempts per episode SHALL be MAX_RETRY+1.

Reset
REQ-027 While rst=1, every channel SHALL be in RESET with cnt=0, rty=0 and cleared sync flops, and outputs SHALL be pll_rst=all-ones, clkout0_gate=0, ready=0, fail=0, lock_lost=0, all_ready=0.
REQ-028 rst asserted mid-operation in any state SHALL reach the values in REQ-027 on the next clkin1 edge; rst SHALL take priority over restart_req.
REQ-029 After rst deasserts, pll_rst SHALL stay high for exactly RST_CYCLES cycles.

Verification (NUM_PLL=2, RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRY=2)
REQ-030 Normal lock: rst released, pll_lock[0] rises 5 cycles after pll_rst[0] falls -> clkout0_gate[0]=ready[0]=1 exactly 10 edges after the first edge sampling lock=1; all_ready=1 only once channel 1 is also ready.
REQ-031 No lock: pll_lock=0 held -> 3 pll_rst pulses of 4 cycles each, separated by 32-cycle waits, then fail=1 with pll_rst held high; the other channel is unaffected.
REQ-032 Glitch: pll_lock low for 3 cycles during STABLE -> no pll_rst pulse, STABLE restarts from cnt=0, and ready is delayed accordingly.
REQ-033 Loss in RUN: pll_lock falls -> clkout0_gate and ready drop 3 edges later, 4-cycle pll_rst pulse, lock_lost=1 sticky, then relock to RUN.
REQ-034 Restart: restart_req in FAIL -> RESET on the next edge; restart_req coincident with STABLE completion -> RESET wins; lock_lost cleared.
REQ-035 Mid-run reset: rst for 1 cycle in RUN -> REQ-027 values next edge, then the full sequence repeats.

Source files
------------

// File: rtl/pll_lock_seq.sv
// PLL lock sequencer.
// Each channel pulses its PLL reset, waits for a synchronised lock, requires
// the lock to be held for a stable window, and then opens the output clock
// gate. Lock timeouts retry a bounded number of times before the channel
// parks in FAIL. Losing lock while running flags lock_lost and starts the
// sequence again.
module pll_lock_seq #(
    parameter int NUM_PLL             = 2,
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRY           = 3
) (
    input  logic               clkin1,
    input  logic               rst,
    input  logic [NUM_PLL-1:0] pll_lock,
    input  logic [NUM_PLL-1:0] restart_req,
    output logic [NUM_PLL-1:0] pll_rst,
    output logic [NUM_PLL-1:0] clkout0_gate,
    output logic [NUM_PLL-1:0] ready,
    output logic [NUM_PLL-1:0] fail,
    output logic [NUM_PLL-1:0] lock_lost,
    output logic               all_ready
);

    // The counter is sized for the longest window; it only ever counts up
    // to (window - 1), so it never wraps inside a state.
    localparam int MAX_RS   = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX  = (MAX_RS > LOCK_TIMEOUT_CYCLES) ? MAX_RS : LOCK_TIMEOUT_CYCLES;
    localparam int CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_LAST   = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    for (genvar ch = 0; ch < NUM_PLL; ch++) begin : gChan

        logic          lockMeta_q;
        logic          lockSync_q;
        state_e        state_q,  state_d;
        logic [CW-1:0] cnt_q,    cnt_d;
        logic [3:0]    rty_q,    rty_d;
        logic          lost_q,   lost_d;
        logic          pllRst_q, pllRst_d;
        logic          gate_q,   gate_d;
        logic          ready_q,  ready_d;
        logic          fail_q,   fail_d;

        // Next-state logic; restart_req overrides every lock or timeout event,
        // and the outputs are decoded from the next state so they register
        // in step with the state they describe.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rty_d   = rty_q;
            lost_d  = lost_q;

            if (restart_req[ch]) begin
                state_d = ST_RESET;
                cnt_d   = '0;
                rty_d   = '0;
                lost_d  = 1'b0;
            end else begin
                case (state_q)
                    ST_RESET: begin
                        if (cnt_q == RST_LAST) begin
                            state_d = ST_WAIT_LOCK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lockSync_q) begin
                            state_d = ST_STABLE;
                            cnt_d   = '0;
                        end else if (cnt_q == TIMEOUT_LAST) begin
                            cnt_d = '0;
                            if (rty_q == RETRY_LAST) begin
                                state_d = ST_FAIL;
                            end else begin
                                state_d = ST_RESET;
                                rty_d   = rty_q + 4'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    ST_STABLE: begin
                        if (!lockSync_q) begin
                            state_d = ST_WAIT_LOCK;
                            cnt_d   = '0;
                        end else if (cnt_q == STABLE_LAST) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (!lockSync_q) begin
                            state_d = ST_RESET;
                            cnt_d   = '0;
                            rty_d   = '0;
                            lost_d  = 1'b1;
                        end
                    end
                    ST_FAIL: begin
                        state_d = ST_FAIL;
                    end
                    default: begin
                        state_d = ST_RESET;
                        cnt_d   = '0;
                        rty_d   = '0;
                    end
                endcase
            end

            pllRst_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
            gate_d   = (state_d == ST_RUN);
            ready_d  = (state_d == ST_RUN);
            fail_d   = (state_d == ST_FAIL);
        end

        // State, counters, lock synchroniser and output registers; rst wins
        // over everything and parks the channel in RESET with PLL reset high.
        always_ff @(posedge clkin1) begin
            if (rst) begin
                lockMeta_q <= 1'b0;
                lockSync_q <= 1'b0;
                state_q    <= ST_RESET;
                cnt_q      <= '0;
                rty_q      <= '0;
                lost_q     <= 1'b0;
                pllRst_q   <= 1'b1;
                gate_q     <= 1'b0;
                ready_q    <= 1'b0;
                fail_q     <= 1'b0;
            end else begin
                lockMeta_q <= pll_lock[ch];
                lockSync_q <= lockMeta_q;
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                rty_q      <= rty_d;
                lost_q     <= lost_d;
                pllRst_q   <= pllRst_d;
                gate_q     <= gate_d;
                ready_q    <= ready_d;
                fail_q     <= fail_d;
            end
        end

        assign pll_rst[ch]      = pllRst_q;
        assign clkout0_gate[ch] = gate_q;
        assign ready[ch]        = ready_q;
        assign fail[ch]         = fail_q;
        assign lock_lost[ch]    = lost_q;
    end

    assign all_ready = &ready;

endmodule
